// File: rtl/w_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : w_stage_ctrl
//  Brief    : Writeback stage. Selects the result source, extends load data,
//             writes the register file and drives the forwarding port.
//  Revision : 1.0 - initial release
// ============================================================================
module w_stage_ctrl #(
    parameter  int XLEN    = 32,
    parameter  int NUM_SRC = 3,
    parameter  int RA_W    = 5,
    parameter  int TIMEOUT = 15,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic [SEL_W-1:0]        x_w_sel,
    input  logic                    x_rd_we,
    input  logic [RA_W-1:0]         x_rd_addr,
    input  logic [1:0]              x_ld_size,
    input  logic                    x_ld_unsigned,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    input  logic                    mem_rvalid,
    input  logic [XLEN-1:0]         mem_rdata,
    input  logic                    w_flush,
    output logic                    rf_we,
    output logic [RA_W-1:0]         rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic                    fwd_valid,
    output logic [RA_W-1:0]         fwd_addr,
    output logic [XLEN-1:0]         fwd_data,
    output logic                    load_busy,
    output logic                    mem_err,
    output logic                    illegal_sel
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam int               SH_W      = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [SEL_W:0]   SRC_LIMIT = (SEL_W + 1)'(NUM_SRC);
    localparam logic [SEL_W-1:0] SEL_MEM   = SEL_W'(1);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [RA_W-1:0]   r_ld_rd;
    logic [1:0]        r_ld_size;
    logic              r_ld_uns;
    logic              r_ld_we;

    logic              w_accept;
    logic              w_sel_bad;
    logic [SEL_W-1:0]  w_src_idx;
    logic              w_latch;
    logic              w_wr;
    logic              w_err;
    logic              w_ill;
    logic [RA_W-1:0]   w_wr_addr;
    logic [XLEN-1:0]   w_wr_data;

    logic [SH_W-1:0]          w_shamt;
    logic [XLEN-1:0]          w_ld_shl;
    logic signed [XLEN-1:0]   w_ld_sra;
    logic [XLEN-1:0]          w_ld_ext;

    assign x_ready   = (r_state == IDLE);
    assign load_busy = (r_state == LOAD_WAIT);
    assign w_accept  = x_valid & x_ready & ~w_flush;
    assign w_sel_bad = ({1'b0, x_w_sel} >= SRC_LIMIT);
    assign w_src_idx = w_sel_bad ? '0 : x_w_sel;

    // Extension by shifting the field to the top and back down; dword on a
    // 32-bit datapath falls into the zero-shift (full word) case.
    always_comb begin
        w_shamt = '0;
        case (r_ld_size)
            2'd0:    w_shamt = SH_W'(XLEN - 8);
            2'd1:    w_shamt = SH_W'(XLEN - 16);
            2'd2:    w_shamt = SH_W'(XLEN - 32);
            default: w_shamt = '0;
        endcase
    end

    assign w_ld_shl = mem_rdata << w_shamt;
    assign w_ld_sra = $signed(w_ld_shl) >>> w_shamt;
    assign w_ld_ext = r_ld_uns ? (w_ld_shl >> w_shamt) : w_ld_sra;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_wr        = 1'b0;
        w_err       = 1'b0;
        w_ill       = 1'b0;
        w_wr_addr   = x_rd_addr;
        w_wr_data   = src_data[w_src_idx*XLEN +: XLEN];
        case (r_state)
            IDLE: begin
                w_err = mem_rvalid;
                if (w_accept) begin
                    if (w_sel_bad) begin
                        w_ill = 1'b1;
                    end else if (x_w_sel == SEL_MEM) begin
                        w_latch     = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = LOAD_WAIT;
                    end else begin
                        w_wr = x_rd_we & (x_rd_addr != '0);
                    end
                end
            end
            LOAD_WAIT: begin
                w_wr_addr = r_ld_rd;
                w_wr_data = w_ld_ext;
                // Flush wins over a coincident data return.
                if (w_flush) begin
                    w_state_nxt = IDLE;
                end else if (mem_rvalid) begin
                    w_wr        = r_ld_we & (r_ld_rd != '0);
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ld_rd   <= '0;
            r_ld_size <= '0;
            r_ld_uns  <= 1'b0;
            r_ld_we   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_ld_rd   <= x_rd_addr;
                r_ld_size <= x_ld_size;
                r_ld_uns  <= x_ld_unsigned;
                r_ld_we   <= x_rd_we;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            mem_err     <= 1'b0;
            illegal_sel <= 1'b0;
        end else begin
            rf_we       <= w_wr;
            mem_err     <= w_err;
            illegal_sel <= w_ill;
            if (w_wr) begin
                rf_waddr <= w_wr_addr;
                rf_wdata <= w_wr_data;
            end
        end
    end

    assign fwd_valid = rf_we;
    assign fwd_addr  = rf_waddr;
    assign fwd_data  = rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_w_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_w_stage_ctrl
//  Brief    : Scoreboard bench for w_stage_ctrl with a rule-level load model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_w_stage_ctrl;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 3;
    localparam int RA_W    = 5;
    localparam int TIMEOUT = 15;
    localparam int SEL_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    x_valid = 1'b0;
    logic                    x_ready;
    logic [SEL_W-1:0]        x_w_sel = '0;
    logic                    x_rd_we = 1'b0;
    logic [RA_W-1:0]         x_rd_addr = '0;
    logic [1:0]              x_ld_size = '0;
    logic                    x_ld_unsigned = 1'b0;
    logic [NUM_SRC*XLEN-1:0] src_data = '0;
    logic                    mem_rvalid = 1'b0;
    logic [XLEN-1:0]         mem_rdata = '0;
    logic                    w_flush = 1'b0;
    logic                    rf_we, fwd_valid, load_busy, mem_err, illegal_sel;
    logic [RA_W-1:0]         rf_waddr, fwd_addr;
    logic [XLEN-1:0]         rf_wdata, fwd_data;

    w_stage_ctrl #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .RA_W(RA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready),
        .x_w_sel(x_w_sel), .x_rd_we(x_rd_we), .x_rd_addr(x_rd_addr),
        .x_ld_size(x_ld_size), .x_ld_unsigned(x_ld_unsigned), .src_data(src_data),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .w_flush(w_flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .load_busy(load_busy), .mem_err(mem_err), .illegal_sel(illegal_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        logic [RA_W-1:0] a;
        logic [XLEN-1:0] d;
    } wr_t;

    wr_t wq[$];
    int  eq[$];
    int  iq[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference load extension: keep the low 'size' bytes, then fill upward.
    function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input logic [1:0] size,
                                            input logic uns);
        int              bits;
        logic [XLEN-1:0] m;
        logic [XLEN-1:0] r;
        bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : (size == 2'd2) ? 32 : 64;
        if (bits > XLEN) bits = XLEN;
        m = (bits == XLEN) ? '1 : ((XLEN'(1) << bits) - XLEN'(1));
        r = v & m;
        if (!uns && v[bits-1]) r = r | ~m;
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        logic ew, ee, ei;
        if (!rst) begin
            ew = 1'b0; ee = 1'b0; ei = 1'b0;
            if (wq.size() > 0) ew = (wq[0].cyc == cyc);
            if (eq.size() > 0) ee = (eq[0] == cyc);
            if (iq.size() > 0) ei = (iq[0] == cyc);
            chk("rf_we", rf_we, ew);
            chk("fwd_valid", fwd_valid, ew);
            chk("mem_err", mem_err, ee);
            chk("illegal_sel", illegal_sel, ei);
            if (ew) begin
                chk("rf_waddr", rf_waddr, wq[0].a);
                chk("rf_wdata", rf_wdata, wq[0].d);
                chk("fwd_addr", fwd_addr, wq[0].a);
                chk("fwd_data", fwd_data, wq[0].d);
                void'(wq.pop_front());
            end
            if (ee) void'(eq.pop_front());
            if (ei) void'(iq.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        x_valid    = 1'b0;
        w_flush    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic alu(input int sel, input logic [RA_W-1:0] rd, input logic we,
                       input logic fl, input logic stray, input logic [NUM_SRC*XLEN-1:0] src);
        chk("x_ready_idle", x_ready, 1'b1);
        x_valid = 1'b1; x_w_sel = SEL_W'(sel); x_rd_addr = rd; x_rd_we = we;
        src_data = src; w_flush = fl; mem_rvalid = stray; mem_rdata = $urandom;
        if (!fl) begin
            if (sel >= NUM_SRC) iq.push_back(cyc + 1);
            else if (we && rd != '0) wq.push_back('{cyc + 1, rd, src[sel*XLEN +: XLEN]});
        end
        if (stray) eq.push_back(cyc + 1);
        step();
        idle_in();
    endtask

    task automatic load(input logic [RA_W-1:0] rd, input logic [1:0] size, input logic uns,
                        input logic we, input int d, input int f, input logic [XLEN-1:0] rdata);
        chk("x_ready_idle", x_ready, 1'b1);
        x_valid = 1'b1; x_w_sel = SEL_W'(1); x_rd_addr = rd; x_rd_we = we;
        x_ld_size = size; x_ld_unsigned = uns; w_flush = 1'b0;
        step();
        idle_in();
        for (int c = 1; c <= TIMEOUT; c++) begin
            chk("x_ready_wait", x_ready, 1'b0);
            chk("load_busy", load_busy, 1'b1);
            // Junk on the execute side must be held off while waiting.
            x_valid = 1'($urandom); x_w_sel = '0; x_rd_addr = RA_W'($urandom_range(1, 31));
            x_rd_we = 1'b1; x_ld_size = 2'($urandom); x_ld_unsigned = 1'($urandom);
            if (f == c) begin
                w_flush = 1'b1;
                if (d == c) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
                step();
                idle_in();
                return;
            end
            if (d == c) begin
                mem_rvalid = 1'b1; mem_rdata = rdata;
                if (we && rd != '0) wq.push_back('{cyc + 1, rd, ext(rdata, size, uns)});
                step();
                idle_in();
                return;
            end
            if (c == TIMEOUT) eq.push_back(cyc + 1);
            step();
        end
        idle_in();
    endtask

    function automatic logic [NUM_SRC*XLEN-1:0] rnd_src();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_waddr", rf_waddr, '0);
        chk("rst_wdata", rf_wdata, '0);
        chk("rst_mem_err", mem_err, 1'b0);
        chk("rst_illegal", illegal_sel, 1'b0);
        chk("rst_busy", load_busy, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_x_ready", x_ready, 1'b1);
        step();

        alu(0, 5'd5, 1'b1, 1'b0, 1'b0, {32'hAAAA_0002, 32'hBBBB_0001, 32'h0000_1234});
        load(5'd9, 2'd0, 1'b0, 1'b1, 3, 0, 32'h0000_0080);
        wq.push_back('{0, 0, 0}); void'(wq.pop_back());
        chk("sext_byte_ref", ext(32'h0000_0080, 2'd0, 1'b0), 32'hFFFF_FF80);
        alu(2, 5'd3, 1'b1, 1'b0, 1'b0, rnd_src());
        load(5'd4, 2'd1, 1'b1, 1'b1, 99, 0, 32'hDEAD_BEEF);
        load(5'd6, 2'd2, 1'b0, 1'b1, 2, 2, 32'h1234_5678);
        alu(0, 5'd0, 1'b1, 1'b0, 1'b0, rnd_src());
        alu(3, 5'd7, 1'b1, 1'b0, 1'b0, rnd_src());
        alu(0, 5'd8, 1'b1, 1'b1, 1'b0, rnd_src());
        alu(0, 5'd10, 1'b1, 1'b0, 1'b1, rnd_src());
        step(); mem_rvalid = 1'b1; eq.push_back(cyc + 1); step(); idle_in();
        load(5'd11, 2'd3, 1'b0, 1'b1, 1, 0, 32'h8765_4321);
        load(5'd12, 2'd1, 1'b0, 1'b1, TIMEOUT, 0, 32'h0000_8001);
        load(5'd13, 2'd0, 1'b1, 1'b1, TIMEOUT, TIMEOUT, 32'h0000_00FF);

        // Asynchronous reset in the middle of a load wait.
        alu(0, 5'd7, 1'b1, 1'b0, 1'b0, rnd_src());
        x_valid = 1'b1; x_w_sel = SEL_W'(1); x_rd_addr = 5'd14; x_rd_we = 1'b1;
        step(); idle_in(); step();
        chk("pre_rst_busy", load_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", load_busy, 1'b0);
        chk("arst_waddr", rf_waddr, '0);
        chk("arst_wdata", rf_wdata, '0);
        chk("arst_rf_we", rf_we, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("post_rst_ready", x_ready, 1'b1);
        step();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 5) begin
                int sel;
                sel = $urandom_range(0, 2);
                if (sel == 1) sel = 3;
                alu(sel, RA_W'($urandom), 1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0), rnd_src());
            end else begin
                load(RA_W'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 7) != 0),
                     $urandom_range(1, TIMEOUT + 2),
                     ($urandom_range(0, 5) == 0) ? $urandom_range(1, TIMEOUT) : 0, $urandom);
            end
            if ($urandom_range(0, 3) == 0) step();
        end

        repeat (3) step();
        chk("wq_drained", wq.size(), 0);
        chk("eq_drained", eq.size(), 0);
        chk("iq_drained", iq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
